// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit toggle flip-flop bank among NREQ requesters.
// Define TFF_ARB_FIXED_PRI_EN for fixed priority (requester 0 highest, no rotating pointer).
module tff_toggle_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] mask_i,
    input  logic                  clr_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [WIDTH-1:0]      t_out_o,
    output logic [WIDTH-1:0]      q_o,
    output logic [WIDTH-1:0]      qb_o,
    output logic                  busy_o
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] t_out_q, t_out_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] mreg_q, mreg_d;
    logic [WIDTH-1:0] q_q, q_d;
`ifndef TFF_ARB_FIXED_PRI_EN
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    w_q, w_d;
    logic [NREQ-1:0]  rot_req;
    logic [PW:0]      sum;
`endif

    logic             found;
    logic [PW-1:0]    win_idx;
    logic [NREQ-1:0]  win_oh;
    logic [WIDTH-1:0] win_mask;

    // Winner search: rotated request vector (round-robin) or plain low-index-first
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
`ifdef TFF_ARB_FIXED_PRI_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
`else
        sum     = '0;
        rot_req = NREQ'({req_i, req_i} >> ptr_q);
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && rot_req[j]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (PW+1)'(j);
                if (sum >= (PW+1)'(NREQ)) begin
                    sum = sum - (PW+1)'(NREQ);
                end
                win_idx = PW'(sum);
            end
        end
`endif
        win_oh   = '0;
        win_mask = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win_idx == PW'(k)) begin
                win_oh[k] = 1'b1;
                win_mask  = mask_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        t_out_d = '0;
        busy_d  = 1'b0;
        mreg_d  = mreg_q;
        q_d     = q_q;
`ifndef TFF_ARB_FIXED_PRI_EN
        ptr_d   = ptr_q;
        w_d     = w_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    gnt_d   = win_oh;
                    t_out_d = win_mask;
                    busy_d  = 1'b1;
                    mreg_d  = win_mask;
`ifndef TFF_ARB_FIXED_PRI_EN
                    w_d     = win_idx;
`endif
                end
            end
            ISSUE: begin
                state_d = IDLE;
                q_d     = q_q ^ mreg_q;
`ifndef TFF_ARB_FIXED_PRI_EN
                ptr_d   = (w_q == PW'(NREQ-1)) ? '0 : w_q + PW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
        // Clear wins over a same-cycle toggle; FSM and pointer still advance
        if (clr_i) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            t_out_q <= '0;
            busy_q  <= 1'b0;
            mreg_q  <= '0;
            q_q     <= '0;
`ifndef TFF_ARB_FIXED_PRI_EN
            ptr_q   <= '0;
            w_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            t_out_q <= t_out_d;
            busy_q  <= busy_d;
            mreg_q  <= mreg_d;
            q_q     <= q_d;
`ifndef TFF_ARB_FIXED_PRI_EN
            ptr_q   <= ptr_d;
            w_q     <= w_d;
`endif
        end
    end

    assign gnt_o   = gnt_q;
    assign t_out_o = t_out_q;
    assign busy_o  = busy_q;
    assign q_o     = q_q;
    assign qb_o    = ~q_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench for tff_toggle_arbiter: expected grant/toggle/state pushed at request time.
module tb_tff_toggle_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  mask_arr [4];
    logic [31:0] mask_flat;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  t_out, q, qb;
    logic        busy;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] t;
        logic [7:0] q;
    } exp_t;

    exp_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] m_q = 8'h00;
    int   m_ptr = 0;

    assign mask_flat = {mask_arr[3], mask_arr[2], mask_arr[1], mask_arr[0]};

    always #5 clk = ~clk;

    tff_toggle_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .mask_i (mask_flat),
        .clr_i  (clr),
        .gnt_o  (gnt),
        .t_out_o(t_out),
        .q_o    (q),
        .qb_o   (qb),
        .busy_o (busy)
    );

    function automatic int pick(input logic [3:0] r);
        int p;
        int k;
`ifdef TFF_ARB_FIXED_PRI_EN
        p = 0;
`else
        p = m_ptr;
`endif
        for (int i = 0; i < 4; i++) begin
            k = (p + i) % 4;
            if (r[k[1:0]]) return k;
        end
        return 0;
    endfunction

    // Model one transaction: expected grant, toggle mask and resulting bank state
    task automatic push_exp(input logic [3:0] r, input logic clr_at_issue);
        exp_t e;
        int   w;
        w     = pick(r);
        e.gnt = 4'(1 << w);
        e.t   = mask_arr[w];
        e.q   = clr_at_issue ? 8'h00 : (m_q ^ e.t);
        sb.push_back(e);
        m_q   = e.q;
        m_ptr = (w + 1) % 4;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
    endtask

    // Waits (bounded) at falling edges for a grant; n = falling edges elapsed
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt === 4'b0 && n < 8);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_q   = 8'h00;
        m_ptr = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        clr   = 1'b0;
        for (int i = 0; i < 4; i++) mask_arr[i] = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            vectors++;
            if (q !== 8'h00) begin miscompares++; $display("FAIL reset_q cyc%0d: got %h exp 00", c, q); end
            vectors++;
            if (qb !== 8'hFF) begin miscompares++; $display("FAIL reset_qb cyc%0d: got %h exp ff", c, qb); end
            vectors++;
            if (gnt !== 4'b0 || busy !== 1'b0) begin
                miscompares++; $display("FAIL reset_gnt_busy cyc%0d: got gnt=%b busy=%b exp 0000/0", c, gnt, busy);
            end
        end
    endtask

    task automatic test_single_toggle();
        exp_t e;
        int   n;
        for (int k = 0; k < 2; k++) begin
            mask_arr[0] = 8'hA5;
            req = 4'b0001;
            push_exp(req, 1'b0);
            wait_gnt(n);
            req = 4'b0;
            mask_arr[0] = 8'h00;
            pop_exp(e);
            vectors++;
            if (n != 1) begin miscompares++; $display("FAIL single_latency: got %0d cycles exp 1", n); end
            vectors++;
            if (gnt !== e.gnt || t_out !== e.t || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single_issue: got gnt=%b t=%h busy=%b exp gnt=%b t=%h busy=1", gnt, t_out, busy, e.gnt, e.t);
            end
            @(negedge clk);
            vectors++;
            if (q !== e.q || qb !== ~e.q) begin
                miscompares++; $display("FAIL single_q: got q=%h qb=%h exp q=%h", q, qb, e.q);
            end
            vectors++;
            if (gnt !== 4'b0 || t_out !== 8'h00 || busy !== 1'b0) begin
                miscompares++; $display("FAIL single_idle: got gnt=%b t=%h busy=%b exp 0000/00/0", gnt, t_out, busy);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   n;
        apply_reset();
        for (int i = 0; i < 4; i++) mask_arr[i] = 8'h01;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_exp(req, 1'b0);
            wait_gnt(n);
            pop_exp(e);
            vectors++;
            if (n != 1) begin miscompares++; $display("FAIL rr_spacing g%0d: got %0d cycles exp 1", k, n); end
            vectors++;
            if (gnt !== e.gnt || t_out !== e.t) begin
                miscompares++; $display("FAIL rr_gnt g%0d: got gnt=%b t=%h exp gnt=%b t=%h", k, gnt, t_out, e.gnt, e.t);
            end
            @(negedge clk);
            vectors++;
            if (q !== e.q || gnt !== 4'b0) begin
                miscompares++; $display("FAIL rr_idle g%0d: got q=%h gnt=%b exp q=%h gnt=0000", k, q, gnt, e.q);
            end
        end
        req = 4'b0;
    endtask

    task automatic test_clear_collision();
        exp_t e;
        int   n;
        apply_reset();
        mask_arr[0] = 8'h0F; mask_arr[1] = 8'hF0; mask_arr[2] = 8'h33; mask_arr[3] = 8'h44;
        for (int k = 0; k < 3; k++) begin
            req = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b1111;
            push_exp(req, k == 1);
            wait_gnt(n);
            req = 4'b0;
            if (k == 1) clr = 1'b1;
            pop_exp(e);
            vectors++;
            if (gnt !== e.gnt || t_out !== e.t) begin
                miscompares++; $display("FAIL clr_gnt t%0d: got gnt=%b t=%h exp gnt=%b t=%h", k, gnt, t_out, e.gnt, e.t);
            end
            @(negedge clk);
            clr = 1'b0;
            vectors++;
            if (q !== e.q) begin miscompares++; $display("FAIL clr_q t%0d: got %h exp %h", k, q, e.q); end
        end
        // Clear while idle
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_q = 8'h00;
        vectors++;
        if (q !== 8'h00 || qb !== 8'hFF) begin miscompares++; $display("FAIL clr_idle: got q=%h qb=%h exp 00/ff", q, qb); end
    endtask

    task automatic test_reset_mid_issue();
        exp_t e;
        int   n;
        mask_arr[1] = 8'hFF;
        req = 4'b0010;
        wait_gnt(n);
        vectors++;
        if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rst_mid_pre: got gnt=%b exp 0010", gnt); end
        rst_n = 1'b0;
        req   = 4'b0;
        #1;
        vectors++;
        if (q !== 8'h00 || qb !== 8'hFF) begin miscompares++; $display("FAIL rst_mid_q: got q=%h qb=%h exp 00/ff", q, qb); end
        vectors++;
        if (gnt !== 4'b0 || busy !== 1'b0 || t_out !== 8'h00) begin
            miscompares++; $display("FAIL rst_mid_out: got gnt=%b busy=%b t=%h exp 0000/0/00", gnt, busy, t_out);
        end
        m_q = 8'h00;
        m_ptr = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (q !== 8'h00) begin miscompares++; $display("FAIL rst_mid_hold: got q=%h exp 00", q); end
        rst_n = 1'b1;
        mask_arr[0] = 8'h11;
        req = 4'b1111;
        push_exp(req, 1'b0);
        wait_gnt(n);
        req = 4'b0;
        pop_exp(e);
        vectors++;
        if (gnt !== e.gnt || t_out !== e.t) begin
            miscompares++; $display("FAIL rst_mid_first: got gnt=%b t=%h exp gnt=%b t=%h", gnt, t_out, e.gnt, e.t);
        end
        @(negedge clk);
        vectors++;
        if (q !== e.q) begin miscompares++; $display("FAIL rst_mid_q_after: got %h exp %h", q, e.q); end
    endtask

    task automatic test_zero_mask();
        exp_t e;
        int   n;
        mask_arr[2] = 8'h00;
        req = 4'b0100;
        push_exp(req, 1'b0);
        wait_gnt(n);
        req = 4'b0;
        pop_exp(e);
        vectors++;
        if (gnt !== e.gnt || t_out !== 8'h00 || busy !== 1'b1) begin
            miscompares++; $display("FAIL zero_issue: got gnt=%b t=%h busy=%b exp gnt=%b t=00 busy=1", gnt, t_out, busy, e.gnt);
        end
        @(negedge clk);
        vectors++;
        if (q !== e.q) begin miscompares++; $display("FAIL zero_q: got %h exp %h", q, e.q); end
`ifdef TFF_ARB_FIXED_PRI_EN
        for (int i = 0; i < 4; i++) mask_arr[i] = 8'h80 >> i;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push_exp(req, 1'b0);
            wait_gnt(n);
            pop_exp(e);
            vectors++;
            if (gnt !== 4'b0001 || t_out !== e.t) begin
                miscompares++; $display("FAIL fixed_gnt g%0d: got gnt=%b t=%h exp gnt=0001 t=%h", k, gnt, t_out, e.t);
            end
            @(negedge clk);
            vectors++;
            if (q !== e.q) begin miscompares++; $display("FAIL fixed_q g%0d: got %h exp %h", k, q, e.q); end
        end
        req = 4'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_single_toggle();
        test_round_robin();
        test_clear_collision();
        test_reset_mid_issue();
        test_zero_mask();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
